hazard_flush_ctrl: RTL and testbench
====================================

Name: hazard_flush_ctrl

Overview:
Pipeline sequencing controller that drives the IF/ID register's ID_write and IF_flush, the PC write enable, and the ID/EX control-bubble select. It detects load-use hazards and inserts bubbles, and it squashes wrong-path instructions on a taken branch resolved in EX. It also freezes the whole pipe while data memory is busy, with a watchdog on that wait. It sits beside the decoder and owns every stall/flush decision in the core.

Parameters:
LU_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
WD_MAX, 255, max consecutive dmem_busy cycles before watchdog trip (1..255)
CNT_W, 16, width of saturating performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
id_rs1  in  5  source reg 1 of instruction in ID
id_rs2  in  5  source reg 2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  5  destination reg of instruction in EX
ex_branch_taken  in  1  branch/jump in EX resolved taken this cycle
dmem_busy  in  1  data memory not ready; freeze pipe
pc_write  out  1  PC update enable
ID_write  out  1  IF/ID load enable (0 = hold)
IF_flush  out  1  clear IF/ID instruction to 0
ex_bubble  out  1  zero control signals entering ID/EX
pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
wd_err  out  1  sticky watchdog trip flag
stall_cnt  out  CNT_W  cycles with pc_write=0, saturating
flush_cnt  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high (clk, rst).
- While rst=1: state=RUN, internal counters=0, wd_err=0, stall_cnt=0, flush_cnt=0, pc_write=0, ID_write=0, IF_flush=1, ex_bubble=1, pipe_freeze=0.
- lu_hit = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Outputs are Mealy: a function of state and current inputs, effective the same cycle. Counters and state are registered.
- Priority, high to low: FREEZE condition > branch flush > load-use stall > normal.
- Default (RUN, no event): pc_write=1, ID_write=1, IF_flush=0, ex_bubble=0, pipe_freeze=0.
- States: RUN, STALL, FREEZE.
- RUN, dmem_busy=1:
  - pipe_freeze=1, pc_write=0, ID_write=0, IF_flush=0, ex_bubble=0.
  - Go to FREEZE with wd counter=1.
  - A simultaneous ex_branch_taken or lu_hit is not acted on this cycle. Inputs are frozen, so the event is re-evaluated after the freeze.
- RUN, ex_branch_taken=1: pc_write=1 (target loads), IF_flush=1, ex_bubble=1, ID_write=1. flush_cnt+1. Stay in RUN. A coincident lu_hit is ignored because the dependent instruction is squashed.
- RUN, lu_hit=1: pc_write=0, ID_write=0, ex_bubble=1. stall_cnt+1.
  - LU_CYCLES=1: stay in RUN.
  - Otherwise: go to STALL with bubble counter=LU_CYCLES-1.
- STALL: same outputs as the load-use cycle; lu_hit is not re-evaluated. Counter decrements each cycle; leave for RUN when the counter reaches 1.
- STALL, dmem_busy=1: FREEZE takes priority. The bubble counter is held and the controller returns to STALL after the freeze.
- FREEZE: freeze outputs as above; stall_cnt+1 per cycle. wd counter increments while dmem_busy=1.
  - dmem_busy=0: next cycle returns to the saved state (RUN or STALL).
  - wd counter==WD_MAX with dmem_busy still 1: set wd_err=1, return to RUN with outputs forced to the branch-flush pattern for one cycle (recovery). wd_err is cleared only by rst.
- Performance counters saturate at all-ones and do not wrap.
- Reset asserted mid-stall or mid-freeze: immediate return to the reset values above; no pending event survives.

Decomposition:
- Shared package: state encoding constants (RUN=2'd0, STALL=2'd1, FREEZE=2'd2), register-index width (5), and zero-register index constant.
- One natural sub-module: sat_counter (parameter W, inc, clk, rst). Instantiate twice, for stall_cnt and flush_cnt.
- Hazard compare stays inline.

Test Plan:
- Reset pulse mid-cycle with rst async -> outputs go to pc_write=0, IF_flush=1, ex_bubble=1 before the next clk edge; counters read 0.
- ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1, LU_CYCLES=1 -> one cycle of pc_write=0/ID_write=0/ex_bubble=1, then RUN; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- LU_CYCLES=3, same hazard -> exactly 3 consecutive bubble cycles; dmem_busy pulsed 2 cycles in the middle -> 3 bubbles plus 2 freeze cycles; stall_cnt=5.
- ex_branch_taken=1 together with lu_hit=1 -> IF_flush=1, ex_bubble=1, pc_write=1, no stall; flush_cnt=1, stall_cnt=0.
- WD_MAX=4, dmem_busy held high 10 cycles -> wd_err=1 after the 4th freeze cycle, one flush cycle, then freeze re-entered; wd_err stays 1 until rst.
- CNT_W=4, 20 forced stall cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/hazard_flush_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
package hazard_flush_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic id_write;
    logic if_flush;
    logic ex_bubble;
    logic pipe_freeze;
  } ctl_t;

  localparam ctl_t CTL_RUN    = '{pc_write: 1'b1, id_write: 1'b1, if_flush: 1'b0, ex_bubble: 1'b0, pipe_freeze: 1'b0};
  localparam ctl_t CTL_FLUSH  = '{pc_write: 1'b1, id_write: 1'b1, if_flush: 1'b1, ex_bubble: 1'b1, pipe_freeze: 1'b0};
  localparam ctl_t CTL_BUBBLE = '{pc_write: 1'b0, id_write: 1'b0, if_flush: 1'b0, ex_bubble: 1'b1, pipe_freeze: 1'b0};
  localparam ctl_t CTL_FREEZE = '{pc_write: 1'b0, id_write: 1'b0, if_flush: 1'b0, ex_bubble: 1'b0, pipe_freeze: 1'b1};
  localparam ctl_t CTL_RESET  = '{pc_write: 1'b0, id_write: 1'b0, if_flush: 1'b1, ex_bubble: 1'b1, pipe_freeze: 1'b0};

endpackage

// File: rtl/hazard_flush_ctrl_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Stall/flush/freeze sequencing for the IF/ID/EX pipe.
// state  | meaning
// RUN    | normal issue; load-use and taken-branch decided combinationally
// STALL  | extra load-use bubbles still owed (lu_cnt_q left)
// FREEZE | dmem busy; saved_q remembers RUN or STALL to resume
module hazard_flush_ctrl
  import hazard_flush_ctrl_pkg::*;
#(
  parameter int LU_CYCLES = 1,
  parameter int WD_MAX    = 255,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             ID_write,
  output logic             IF_flush,
  output logic             ex_bubble,
  output logic             pipe_freeze,
  output logic             wd_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] LU_INIT = 3'(LU_CYCLES - 1);
  localparam logic [7:0] WD_LIM  = 8'(WD_MAX);

  state_e     state_q, state_d, saved_q, saved_d, eff_state;
  logic [2:0] lu_cnt_q, lu_cnt_d;
  logic [7:0] wd_cnt_q, wd_cnt_d, wd_next;
  logic       rec_q, rec_d;
  logic       wd_err_q, wd_err_d;
  logic       lu_hit, flush_inc;
  ctl_t       ctl;

  assign lu_hit = ex_mem_read && (ex_rd != REG_ZERO) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  // Once dmem releases, the frozen state's own behaviour applies in that same cycle.
  assign eff_state = (state_q == ST_FREEZE) ? saved_q : state_q;
  assign wd_next   = (state_q == ST_FREEZE) ? wd_cnt_q + 8'd1 : 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      saved_q  <= ST_RUN;
      lu_cnt_q <= '0;
      wd_cnt_q <= '0;
      rec_q    <= 1'b0;
      wd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      lu_cnt_q <= lu_cnt_d;
      wd_cnt_q <= wd_cnt_d;
      rec_q    <= rec_d;
      wd_err_q <= wd_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    lu_cnt_d = lu_cnt_q;
    wd_cnt_d = '0;
    rec_d    = 1'b0;
    wd_err_d = wd_err_q;
    if (rec_q) begin
      state_d = ST_RUN;
    end else if (dmem_busy) begin
      if (wd_next == WD_LIM) begin
        wd_err_d = 1'b1;
        rec_d    = 1'b1;
        state_d  = ST_RUN;
      end else begin
        state_d  = ST_FREEZE;
        wd_cnt_d = wd_next;
        if (state_q != ST_FREEZE) saved_d = state_q;
      end
    end else begin
      case (eff_state)
        ST_STALL: begin
          if (lu_cnt_q == 3'd1) begin
            state_d = ST_RUN;
          end else begin
            state_d  = ST_STALL;
            lu_cnt_d = lu_cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          if (!ex_branch_taken && lu_hit && (LU_CYCLES > 1)) begin
            state_d  = ST_STALL;
            lu_cnt_d = LU_INIT;
          end
        end
      endcase
    end
  end

  always_comb begin
    ctl       = CTL_RUN;
    flush_inc = 1'b0;
    if (rst) begin
      ctl = CTL_RESET;
    end else if (rec_q) begin
      ctl = CTL_FLUSH;
    end else if (dmem_busy) begin
      ctl = CTL_FREEZE;
    end else if (eff_state == ST_STALL) begin
      ctl = CTL_BUBBLE;
    end else if (ex_branch_taken) begin
      ctl       = CTL_FLUSH;
      flush_inc = 1'b1;
    end else if (lu_hit) begin
      ctl = CTL_BUBBLE;
    end
  end

  assign pc_write    = ctl.pc_write;
  assign ID_write    = ctl.id_write;
  assign IF_flush    = ctl.if_flush;
  assign ex_bubble   = ctl.ex_bubble;
  assign pipe_freeze = ctl.pipe_freeze;
  assign wd_err      = wd_err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (!ctl.pc_write),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Scoreboard bench: three controller configurations share stimulus; one is checked per vector.
module tb_hazard_flush_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_mem_read = 1'b0;
  logic       ex_branch_taken = 1'b0, dmem_busy = 1'b0;

  logic        pc0, idw0, iff0, bub0, frz0, wd0;
  logic        pc1, idw1, iff1, bub1, frz1, wd1;
  logic        pc2, idw2, iff2, bub2, frz2, wd2;
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [3:0]  sc2, fc2;

  always #5 clk = ~clk;

  hazard_flush_ctrl #(.LU_CYCLES(1), .WD_MAX(255), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy), .pc_write(pc0), .ID_write(idw0),
    .IF_flush(iff0), .ex_bubble(bub0), .pipe_freeze(frz0), .wd_err(wd0),
    .stall_cnt(sc0), .flush_cnt(fc0));

  hazard_flush_ctrl #(.LU_CYCLES(3), .WD_MAX(4), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy), .pc_write(pc1), .ID_write(idw1),
    .IF_flush(iff1), .ex_bubble(bub1), .pipe_freeze(frz1), .wd_err(wd1),
    .stall_cnt(sc1), .flush_cnt(fc1));

  hazard_flush_ctrl #(.LU_CYCLES(1), .WD_MAX(255), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy), .pc_write(pc2), .ID_write(idw2),
    .IF_flush(iff2), .ex_bubble(bub2), .pipe_freeze(frz2), .wd_err(wd2),
    .stall_cnt(sc2), .flush_cnt(fc2));

  // Output pattern bits: {pc_write, ID_write, IF_flush, ex_bubble, pipe_freeze, wd_err}
  localparam logic [5:0] NORM = 6'b110000;
  localparam logic [5:0] RSTO = 6'b001100;
  localparam logic [5:0] BUB  = 6'b000100;
  localparam logic [5:0] FLU  = 6'b111100;
  localparam logic [5:0] FRZ  = 6'b000010;
  localparam logic [5:0] WDB  = 6'b000001;

  typedef struct {
    int         d;
    logic [5:0] o;
    int         sc;
    int         fc;
    int         id;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vid     = 0;
  logic [5:0]  act_o;
  logic [15:0] act_sc, act_fc;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      case (mon_e.d)
        0:       begin act_o = {pc0, idw0, iff0, bub0, frz0, wd0}; act_sc = sc0; act_fc = fc0; end
        1:       begin act_o = {pc1, idw1, iff1, bub1, frz1, wd1}; act_sc = sc1; act_fc = fc1; end
        default: begin act_o = {pc2, idw2, iff2, bub2, frz2, wd2}; act_sc = {12'd0, sc2}; act_fc = {12'd0, fc2}; end
      endcase
      n_tests++;
      if (act_o !== mon_e.o) begin
        n_fail++;
        $display("FAIL vec%0d outputs: got %b want %b", mon_e.id, act_o, mon_e.o);
      end
      n_tests++;
      if (act_sc !== 16'(mon_e.sc)) begin
        n_fail++;
        $display("FAIL vec%0d stall_cnt: got %0d want %0d", mon_e.id, act_sc, mon_e.sc);
      end
      n_tests++;
      if (act_fc !== 16'(mon_e.fc)) begin
        n_fail++;
        $display("FAIL vec%0d flush_cnt: got %0d want %0d", mon_e.id, act_fc, mon_e.fc);
      end
    end
  end

  // Inputs change 1ns after the edge, so rst here also exercises the asynchronous path.
  task automatic vec(input int d, input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                     input logic br, input logic busy, input logic [5:0] eo,
                     input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br; dmem_busy = busy;
    e.d = d; e.o = eo; e.sc = sc; e.fc = fc; e.id = vid;
    q.push_back(e);
    vid++;
  endtask

  task automatic idle(input int d, input logic r, input logic busy, input logic [5:0] eo,
                      input int sc, input int fc);
    vec(d, r, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, busy, eo, sc, fc);
  endtask

  task automatic haz(input int d, input logic [5:0] eo, input int sc, input int fc);
    vec(d, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, eo, sc, fc);
  endtask

  initial begin
    // LU_CYCLES=1 configuration
    idle(0, 1'b1, 1'b0, RSTO, 0, 0);
    idle(0, 1'b0, 1'b0, NORM, 0, 0);
    haz(0, BUB, 0, 0);
    idle(0, 1'b0, 1'b0, NORM, 1, 0);
    vec(0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, NORM, 1, 0);
    vec(0, 1'b0, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, BUB, 1, 0);
    vec(0, 1'b0, 5'd3, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, NORM, 2, 0);
    vec(0, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, FLU, 2, 0);
    idle(0, 1'b0, 1'b0, NORM, 2, 1);
    vec(0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, FRZ, 2, 1);
    vec(0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, FLU, 3, 1);
    idle(0, 1'b0, 1'b0, NORM, 3, 2);
    idle(0, 1'b1, 1'b0, RSTO, 0, 0);

    // LU_CYCLES=3, WD_MAX=4 configuration
    idle(1, 1'b0, 1'b0, NORM, 0, 0);
    haz(1, BUB, 0, 0);
    idle(1, 1'b0, 1'b0, BUB, 1, 0);
    idle(1, 1'b0, 1'b0, BUB, 2, 0);
    idle(1, 1'b0, 1'b0, NORM, 3, 0);
    haz(1, BUB, 3, 0);
    idle(1, 1'b0, 1'b1, FRZ, 4, 0);
    idle(1, 1'b0, 1'b1, FRZ, 5, 0);
    idle(1, 1'b0, 1'b0, BUB, 6, 0);
    idle(1, 1'b0, 1'b0, BUB, 7, 0);
    idle(1, 1'b0, 1'b0, NORM, 8, 0);
    idle(1, 1'b0, 1'b1, FRZ, 8, 0);
    idle(1, 1'b0, 1'b1, FRZ, 9, 0);
    idle(1, 1'b0, 1'b1, FRZ, 10, 0);
    idle(1, 1'b0, 1'b1, FRZ, 11, 0);
    idle(1, 1'b0, 1'b1, FLU | WDB, 12, 0);
    idle(1, 1'b0, 1'b1, FRZ | WDB, 12, 0);
    idle(1, 1'b0, 1'b1, FRZ | WDB, 13, 0);
    idle(1, 1'b0, 1'b1, FRZ | WDB, 14, 0);
    idle(1, 1'b0, 1'b1, FRZ | WDB, 15, 0);
    idle(1, 1'b0, 1'b1, FLU | WDB, 16, 0);
    idle(1, 1'b0, 1'b0, NORM | WDB, 16, 0);
    idle(1, 1'b1, 1'b0, RSTO, 0, 0);

    // CNT_W=4 configuration: counter saturation
    idle(2, 1'b0, 1'b0, NORM, 0, 0);
    for (int i = 0; i < 20; i++) idle(2, 1'b0, 1'b1, FRZ, (i < 15) ? i : 15, 0);
    idle(2, 1'b0, 1'b0, NORM, 15, 0);
    idle(2, 1'b0, 1'b0, NORM, 15, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
